instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path constants, FSM encoding and small address helpers.
package riscv_pkg;

  // Width of one instruction word and of one fetch address.
  localparam int INSTR_W = 32;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Fetch FSM encoding.
  //   IDLE : no request outstanding
  //   REQ  : request outstanding, its response will be kept
  //   DROP : request outstanding, its response will be thrown away
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One instruction buffer entry: the fetch address and the word fetched.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // Sequential successor; wraps from 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding fetched {pc, instr} entries between fetch and decode.
// The head entry is visible combinationally; an empty buffer presents zeros.
// Flush has priority over push and pop and empties the buffer in one cycle.
module fetch_buffer #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  // Pointer advance that also works for depths that are not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;

  // A flush cancels any push or pop requested in the same cycle.
  assign push_en = push & ~full  & ~flush;
  assign pop_en  = pop  & ~empty & ~flush;

  // Zero the head when empty so stale storage never leaks to decode.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy; simultaneous push+pop keeps count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_en && !pop_en) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_en && pop_en) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents only matter while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time to instruction
// memory, queues the returned words with their addresses for decode, and
// handles branch/jump redirects including responses still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  import riscv_pkg::*;

  localparam int               CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(BUF_DEPTH);
  // Aligned so imem_addr keeps bits [1:0] at zero even for an odd parameter.
  localparam logic [31:0]      RESET_PC_A = RESET_PC & ~32'h0000_0003;

  fetch_state_e     state_q;
  logic [31:0]      pc_q, pc_d;
  logic             imem_req_q;
  logic [31:0]      imem_addr_q;
  logic             started_q;
  logic [31:0]      redirect_target;
  logic             can_issue;

  fetch_entry_t     buf_wdata;
  fetch_entry_t     head_entry;
  logic             buf_push;
  logic             buf_pop;
  logic             buf_flush;
  logic [CNT_W-1:0] buf_count;
  logic             buf_empty;
  logic             buf_full;

  assign redirect_target = align_pc(redirect_pc);

  // A new fetch needs buffer room and one settled cycle after reset release.
  assign can_issue = started_q && (buf_count < DEPTH_C);

  // Redirect outranks everything: it flushes, and it suppresses the push of
  // a response arriving in the same cycle as well as any pop.
  assign buf_flush = redirect_valid;
  assign buf_push  = (state_q == REQ) & imem_ack & ~redirect_valid & ~buf_full;
  assign buf_pop   = instr_valid & instr_ready & ~redirect_valid;
  assign buf_wdata = '{pc: pc_q, instr: imem_rdata};

  // Next fetch pc: redirect target, else advance on a kept response.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if ((state_q == REQ) && imem_ack) begin
      pc_d = next_seq_pc(pc_q);
    end
  end

  // Fetch FSM with registered request outputs and post-reset holdoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC_A;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC_A;
      started_q   <= 1'b0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      case (state_q)
        IDLE: begin
          if (!redirect_valid && can_issue) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end
        end
        REQ: begin
          // A response always retires the request; redirect alone means the
          // eventual response must be discarded.
          if (imem_ack) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end else if (redirect_valid) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          // Request and address stay up until memory answers.
          if (imem_ack) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .reset     (reset),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (buf_pop),
    .head_data (head_entry),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign instr_valid = ~buf_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

endmodule
